regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port (waddr/wdata/we) between the in-order
//  pipeline writeback stage and the long-latency multiply/divide unit (MDU).
//  Pipeline writeback always wins. MDU results are buffered in a small FIFO and drained
//  into idle write slots. The block exports a pending-write mask for decode hazard
//  stalls, and raises a stall request when an MDU result starves.
// PARAMETERS
//  DEPTH       2   MDU result FIFO entries; power of 2, >= 2
//  STARVE_MAX  8   cycles a valid FIFO head may wait before stall_req asserts; >= 1
// PORTS
//  cpu_clk_75M  in   1   core clock; all state on rising edge
//  cpu_rst      in   1   asynchronous reset, active-high
//  wb_we        in   1   pipeline writeback enable; no backpressure
//  wb_waddr     in   5   pipeline writeback address
//  wb_wdata     in   32  pipeline writeback data
//  mdu_valid    in   1   MDU result valid
//  mdu_ready    out  1   FIFO can accept; push = mdu_valid & mdu_ready
//  mdu_waddr    in   5   MDU destination register
//  mdu_wdata    in   32  MDU result
//  rf_we        out  1   to register file we
//  rf_waddr     out  5   to register file waddr
//  rf_wdata     out  32  to register file wdata
//  pend_mask    out  32  bit i = live queued write to register i
//  stall_req    out  1   registered; asks the pipeline to free a writeback slot
//  fifo_cnt     out  $clog2(DEPTH+1)  occupied entries, including killed entries
// BEHAVIOUR
//  - Reset (async, cpu_rst=1):
//    - FIFO empty, all entry valid bits 0, age=0.
//    - stall_req=0, pend_mask=0, mdu_ready=0, rf_we=0.
//    - Outputs stay forced while reset is held.
//    - A reset mid-drain discards all queued results.
//  - FIFO entry = {live, waddr, wdata}. mdu_ready = (fifo_cnt != DEPTH); combinational.
//  - Write port mux, combinational, zero added latency:
//    - If wb_we: rf_we=1, rf_waddr/rf_wdata = wb_*.
//    - Else if the head is live: rf_* = head; rf_we=1; pop.
//    - Else: rf_we=0.
//  - A killed (non-live) head pops in any cycle, even when wb_we=1, and never drives rf_we.
//  - Push rules:
//    - A push with mdu_waddr=0 is accepted (ready honoured) but not enqueued.
//    - A push in the same cycle as wb_we with wb_waddr==mdu_waddr (nonzero) is accepted but
//      not enqueued: the writeback instruction is younger and its value supersedes.
//  - WAW kill: when wb_we=1 and wb_waddr matches any live queued entry, those entries'
//    live bits clear at the clock edge. They remain occupied until popped.
//  - Push and pop in the same cycle are both allowed. The count stays unchanged.
//    The push is gated by the pre-edge mdu_ready.
//  - pend_mask is registered. It is the OR of one-hot(waddr) over live entries after the
//    edge's push, pop and kill updates. Bit 0 is never set.
//  - Age counter:
//    - Clears on any pop, or when the head is not live.
//    - Otherwise increments while the live head waits; saturates at STARVE_MAX.
//    - stall_req <= (age == STARVE_MAX-1 and head not popping) or (stall_req and head live,
//      not popping). stall_req drops the edge after the head pops.
//  - Pointers wrap modulo DEPTH. fifo_cnt saturates logically at DEPTH (no overflow,
//    because ready is low when full).
//  - wb_we with wb_waddr=0 is passed through unchanged; the register file ignores it.
// TESTING
//  1. Reset: cpu_rst=1 mid-cycle -> rf_we, stall_req, mdu_ready, pend_mask all 0
//     immediately. Release -> mdu_ready=1, fifo_cnt=0.
//  2. Idle drain: wb_we=0; push {r5,32'hDEAD_BEEF}.
//     -> Next cycle: pend_mask=32'h20, rf_we=1, rf_waddr=5, rf_wdata=DEADBEEF.
//     -> Following edge: pend_mask=0, fifo_cnt=0.
//  3. Full/backpressure: wb_we=1 (r1) continuously; push r2, r3.
//     -> fifo_cnt=2, mdu_ready=0, third push held.
//     -> Drop wb_we: r2 writes, then r3, in order.
//  4. WAW kill: queue r7; next cycle wb_we=1 r7 = 32'h1.
//     -> pend_mask bit 7 clears.
//     -> Queued r7 pops with rf_we=0; register 7 ends at 32'h1.
//  5. Starvation: queue r4; hold wb_we=1 (r9).
//     -> stall_req rises after STARVE_MAX=8 cycles.
//     -> Drop wb_we one cycle: r4 written; stall_req falls next edge.
//  6. Same-cycle conflict: wb_we=1 r3 and push r3 together -> push accepted, not enqueued;
//     fifo_cnt stays 0. Push r0 -> also not enqueued.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port between the in-order pipeline
//   writeback stage and the multiply/divide unit (MDU). Writeback always wins.
//   MDU results are buffered in a small FIFO and drained into idle write slots.
//   Queued results whose destination is overwritten by a younger writeback are
//   killed in place and later popped without writing.
//
// Ports
//   cpu_clk_75M  core clock, rising edge
//   cpu_rst      asynchronous reset, active-high
//   wb_we/wb_waddr/wb_wdata        pipeline writeback (no backpressure)
//   mdu_valid/mdu_ready            MDU result handshake
//   mdu_waddr/mdu_wdata            MDU result destination and value
//   rf_we/rf_waddr/rf_wdata        register-file write port
//   pend_mask    registered, bit i = live queued write to register i
//   stall_req    registered, asks the pipeline to free a writeback slot
//   fifo_cnt     occupied FIFO entries, killed entries included
module regfile_wb_arbiter #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic                         cpu_clk_75M,
    input  logic                         cpu_rst,
    input  logic                         wb_we,
    input  logic [4:0]                   wb_waddr,
    input  logic [31:0]                  wb_wdata,
    input  logic                         mdu_valid,
    output logic                         mdu_ready,
    input  logic [4:0]                   mdu_waddr,
    input  logic [31:0]                  mdu_wdata,
    output logic                         rf_we,
    output logic [4:0]                   rf_waddr,
    output logic [31:0]                  rf_wdata,
    output logic [31:0]                  pend_mask,
    output logic                         stall_req,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(STARVE_MAX + 1);

    // Live bits are cleared on pop, so a set live bit always implies an
    // occupied slot; no separate occupancy vector is needed.
    logic [DEPTH-1:0] live_q, live_d;
    logic [4:0]       addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    cnt;
    logic [AW-1:0]    age;
    logic [31:0]      pend_q, pend_d;
    logic             stall_q, stall_d;

    logic             nempty, full, head_live, pop, push, enq;

    assign nempty    = (cnt != '0);
    assign full      = (cnt == CW'(DEPTH));
    assign head_live = live_q[rd_ptr];
    // A killed head drains even while writeback owns the port.
    assign pop       = nempty & (~head_live | ~wb_we);
    assign mdu_ready = ~cpu_rst & ~full;
    assign push      = mdu_valid & mdu_ready;
    // Writes to r0 and writes superseded by a same-cycle writeback are
    // acknowledged but dropped.
    assign enq       = push & (mdu_waddr != 5'd0)
                       & ~(wb_we & (wb_waddr == mdu_waddr));

    assign pend_mask = pend_q;
    assign stall_req = stall_q;
    assign fifo_cnt  = cnt;

    // Write port mux
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (!cpu_rst) begin
            if (wb_we) begin
                rf_we    = 1'b1;
                rf_waddr = wb_waddr;
                rf_wdata = wb_wdata;
            end else if (head_live) begin
                rf_we    = 1'b1;
                rf_waddr = addr_q[rd_ptr];
                rf_wdata = data_q[rd_ptr];
            end
        end
    end

    // Next live bits and pending mask after kill, pop and push
    always_comb begin
        live_d = live_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (wb_we && live_q[i] && (addr_q[i] == wb_waddr))
                live_d[i] = 1'b0;
        end
        if (pop)
            live_d[rd_ptr] = 1'b0;
        if (enq)
            live_d[wr_ptr] = 1'b1;

        pend_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (live_d[i]) begin
                if (enq && (wr_ptr == PW'(i)))
                    pend_d[mdu_waddr] = 1'b1;
                else
                    pend_d[addr_q[i]] = 1'b1;
            end
        end
    end

    assign stall_d = head_live & ~pop & ((age == AW'(STARVE_MAX - 1)) | stall_q);

    always_ff @(posedge cpu_clk_75M or posedge cpu_rst) begin
        if (cpu_rst) begin
            live_q  <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            cnt     <= '0;
            age     <= '0;
            pend_q  <= '0;
            stall_q <= 1'b0;
        end else begin
            live_q  <= live_d;
            pend_q  <= pend_d;
            stall_q <= stall_d;
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (enq)
                wr_ptr <= wr_ptr + PW'(1);
            if (enq && !pop)
                cnt <= cnt + CW'(1);
            else if (pop && !enq)
                cnt <= cnt - CW'(1);
            if (pop || !head_live)
                age <= '0;
            else if (age != AW'(STARVE_MAX))
                age <= age + AW'(1);
        end
    end

    // Payload storage needs no reset; live bits qualify it.
    always_ff @(posedge cpu_clk_75M) begin
        if (enq) begin
            addr_q[wr_ptr] <= mdu_waddr;
            data_q[wr_ptr] <= mdu_wdata;
        end
    end

endmodule
